ecc_secded_pipe: RTL

ECC_SECDED_PIPE -- requirements
Module: ecc_secded_pipe

---
 rtl/ecc_secded_pipe.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/ecc_secded_pipe.sv
// ecc_secded_pipe: Hamming SECDED encoder with error injection, plus a
// two-stage decoder with valid/ready flow control, saturating error
// counters and sticky capture of the first nonzero syndrome.
//
// Handshake rule (decode input and output): a word moves across an
// interface on a rising edge where valid and ready are both 1; once valid
// is raised the payload is held until that transfer happens, and ready may
// depend combinationally on the downstream ready.
//
// Codeword layout: positions 1..CW_LEN, check bit i at position 2^i, data
// bit k at the k-th position that is not a power of two. The top parity bit
// is the even parity of the whole word.
module ecc_secded_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH = 16,
  localparam int PARITY_WIDTH =
    ((2**4 >= DATA_WIDTH + 4) ? 4 :
     (2**5 >= DATA_WIDTH + 5) ? 5 :
     (2**6 >= DATA_WIDTH + 6) ? 6 :
     (2**7 >= DATA_WIDTH + 7) ? 7 : 8) + 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enc_valid,
  input  logic [DATA_WIDTH-1:0]            enc_data,
  output logic                             enc_out_valid,
  output logic [DATA_WIDTH-1:0]            enc_out_data,
  output logic [PARITY_WIDTH-1:0]          enc_out_parity,
  input  logic                             inj_en,
  input  logic [PARITY_WIDTH+DATA_WIDTH-1:0] inj_mask,
  input  logic                             dec_in_valid,
  output logic                             dec_in_ready,
  input  logic [DATA_WIDTH-1:0]            dec_in_data,
  input  logic [PARITY_WIDTH-1:0]          dec_in_parity,
  input  logic                             dec_in_bypass,
  output logic                             dec_out_valid,
  input  logic                             dec_out_ready,
  output logic [DATA_WIDTH-1:0]            dec_out_data,
  output logic                             dec_out_sbit,
  output logic                             dec_out_dbit,
  output logic [PARITY_WIDTH-1:0]          dec_out_syndrome,
  input  logic                             cnt_clr,
  output logic [CNT_WIDTH-1:0]             sbit_cnt,
  output logic [CNT_WIDTH-1:0]             dbit_cnt,
  output logic                             first_err_vld,
  output logic [PARITY_WIDTH-1:0]          first_err_syndrome
);

  localparam int HAM_BITS = PARITY_WIDTH - 1;
  localparam int CW_LEN   = DATA_WIDTH + HAM_BITS;

  // Data bits that feed Hamming check bit i.
  function automatic logic [DATA_WIDTH-1:0] cover_mask(input int i);
    logic [DATA_WIDTH-1:0] m;
    int k;
    m = '0;
    k = 0;
    for (int pos = 1; pos <= CW_LEN; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (((pos >> i) & 1) != 0) m = m | (DATA_WIDTH'(1) << k);
        k++;
      end
    end
    return m;
  endfunction

  // Codeword position occupied by data bit k.
  function automatic int data_pos(input int k);
    int n;
    int r;
    n = 0;
    r = 0;
    for (int pos = 1; pos <= CW_LEN; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (n == k) r = pos;
        n++;
      end
    end
    return r;
  endfunction

  logic [HAM_BITS-1:0]     enc_ham;
  logic [HAM_BITS-1:0]     dec_ham;
  logic [PARITY_WIDTH-1:0] enc_par;
  logic [PARITY_WIDTH-1:0] in_syn;

  logic                    s1_valid;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic                    s1_bypass;
  logic [PARITY_WIDTH-1:0] s1_syn;

  logic                    s2_valid;
  logic [DATA_WIDTH-1:0]   s2_data;
  logic                    s2_sbit;
  logic                    s2_dbit;
  logic                    s2_bypass;
  logic [PARITY_WIDTH-1:0] s2_syn;

  logic [DATA_WIDTH-1:0]   pos_hit;
  logic [DATA_WIDTH-1:0]   corr_data;
  logic                    c_sbit;
  logic                    c_dbit;
  logic                    s1_adv;
  logic                    s2_adv;
  logic                    out_hs;

  for (genvar g = 0; g < HAM_BITS; g++) begin : g_cov
    localparam logic [DATA_WIDTH-1:0] COV = cover_mask(g);
    assign enc_ham[g] = ^(enc_data & COV);
    assign dec_ham[g] = ^(dec_in_data & COV);
  end

  // One-hot of the data bit whose position matches the stage-1 syndrome.
  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_pos
    localparam int POS = data_pos(g);
    assign pos_hit[g] = (s1_syn[HAM_BITS-1:0] == HAM_BITS'(POS));
  end

  // Top bit covers data and the other check bits so the whole word is even.
  assign enc_par = {(^enc_data) ^ (^enc_ham), enc_ham};

  // Top syndrome bit is the parity of the entire received word, so any
  // single flip (data or check) sets it and any double flip clears it.
  assign in_syn = {(^dec_in_data) ^ (^dec_in_parity),
                   dec_in_parity[HAM_BITS-1:0] ^ dec_ham};

  assign s2_adv       = !s2_valid || dec_out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign dec_in_ready = s1_adv;
  assign out_hs       = s2_valid && dec_out_ready;

  // Encode register: one-cycle latency, optional injection mask on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_out_valid  <= 1'b0;
      enc_out_data   <= '0;
      enc_out_parity <= '0;
    end else begin
      enc_out_valid <= enc_valid;
      if (enc_valid) begin
        {enc_out_parity, enc_out_data} <= {enc_par, enc_data} ^
                                          (inj_en ? inj_mask : '0);
      end
    end
  end

  // Decode stage 1: capture received data, bypass and raw syndrome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_bypass <= 1'b0;
      s1_syn    <= '0;
    end else if (s1_adv) begin
      s1_valid <= dec_in_valid;
      if (dec_in_valid) begin
        s1_data   <= dec_in_data;
        s1_bypass <= dec_in_bypass;
        s1_syn    <= in_syn;
      end
    end
  end

  // Classify the stage-1 syndrome and build corrected data and flags.
  always_comb begin
    corr_data = s1_data;
    c_sbit    = 1'b0;
    c_dbit    = 1'b0;
    if (!s1_bypass && (s1_syn != '0)) begin
      if (!s1_syn[HAM_BITS]) begin
        c_dbit = 1'b1;
      end else if (|pos_hit) begin
        corr_data = s1_data ^ pos_hit;
        c_sbit    = 1'b1;
      end else if ((s1_syn[HAM_BITS-1:0] &
                    (s1_syn[HAM_BITS-1:0] - HAM_BITS'(1))) == '0) begin
        c_sbit = 1'b1;
      end else begin
        c_dbit = 1'b1;
      end
    end
  end

  // Decode stage 2: output register, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_sbit   <= 1'b0;
      s2_dbit   <= 1'b0;
      s2_bypass <= 1'b0;
      s2_syn    <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data   <= corr_data;
        s2_sbit   <= c_sbit;
        s2_dbit   <= c_dbit;
        s2_bypass <= s1_bypass;
        s2_syn    <= s1_syn;
      end
    end
  end

  // Error counters and first-error capture; clear beats same-cycle updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbit_cnt           <= '0;
      dbit_cnt           <= '0;
      first_err_vld      <= 1'b0;
      first_err_syndrome <= '0;
    end else if (cnt_clr) begin
      sbit_cnt      <= '0;
      dbit_cnt      <= '0;
      first_err_vld <= 1'b0;
    end else if (out_hs) begin
      if (s2_sbit && (sbit_cnt != {CNT_WIDTH{1'b1}})) sbit_cnt <= sbit_cnt + 1'b1;
      if (s2_dbit && (dbit_cnt != {CNT_WIDTH{1'b1}})) dbit_cnt <= dbit_cnt + 1'b1;
      if (!first_err_vld && !s2_bypass && (s2_syn != '0)) begin
        first_err_vld      <= 1'b1;
        first_err_syndrome <= s2_syn;
      end
    end
  end

  assign dec_out_valid    = s2_valid;
  assign dec_out_data     = s2_data;
  assign dec_out_sbit     = s2_sbit;
  assign dec_out_dbit     = s2_dbit;
  assign dec_out_syndrome = s2_syn;

endmodule
